// File: rtl/pwr_seq_pkg.sv
// Shared state encoding, widths and delay-load helper for the exec-domain power sequencer.
package pwr_seq_pkg;

    localparam logic [2:0] PWR_ST_ON     = 3'd0;
    localparam logic [2:0] PWR_ST_ISO    = 3'd1;
    localparam logic [2:0] PWR_ST_OFF    = 3'd2;
    localparam logic [2:0] PWR_ST_PWRUP  = 3'd3;
    localparam logic [2:0] PWR_ST_RSTREL = 3'd4;

    typedef enum logic [2:0] {
        ST_ON     = PWR_ST_ON,
        ST_ISO    = PWR_ST_ISO,
        ST_OFF    = PWR_ST_OFF,
        ST_PWRUP  = PWR_ST_PWRUP,
        ST_RSTREL = PWR_ST_RSTREL
    } pwr_state_t;

    localparam int TMR_W  = 4;
    localparam int IDLE_W = 8;
    localparam int WAKE_W = 16;

    // The timer reports done on the cycle it reads zero, so an N-cycle hold loads N-1.
    function automatic logic [TMR_W-1:0] dly_load(input int unsigned dly);
        return TMR_W'(dly - 1);
    endfunction

endpackage

// File: rtl/pwr_seq_timer.sv
// Loadable 4-bit down-counter shared by the ISO, PWRUP and RSTREL hold phases.
module pwr_seq_timer
    import pwr_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic             done,
    output logic             done_next
);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done      = (cnt_q == '0);
    assign done_next = (cnt_d == '0);

endmodule

// File: rtl/pwr_seq_ctrl.sv
// Exec-domain power-gating sequencer: idle detect, isolate, power off, wake, reset release.
// Optional retention save/restore strobes are built when PWR_SEQ_RETENTION_EN is defined.
//
// state  | meaning
// ON     | domain powered; counting consecutive idle cycles
// ISO    | outputs clamped, power still on; wake/disable aborts back to ON
// OFF    | power removed, outputs clamped; waits for wake or disable
// PWRUP  | power restored, domain held in reset while rails settle
// RSTREL | reset still held for release window, then back to ON
module pwr_seq_ctrl
    import pwr_seq_pkg::*;
#(
    parameter int IDLE_CYCLES = 16,
    parameter int ISO_DLY     = 2,
    parameter int PWRUP_DLY   = 4,
    parameter int RST_CYCLES  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pwr_en,
    input  logic              ififo_rdy,
    input  logic              exec_idle,
    output logic              pwr_down,
    output logic              iso_enable,
    output logic              pwron_reset,
    output logic [2:0]        pwr_state,
    output logic [WAKE_W-1:0] wake_cnt
`ifdef PWR_SEQ_RETENTION_EN
    ,
    output logic              ret_save,
    output logic              ret_restore
`endif
);

    localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(IDLE_CYCLES - 1);
    localparam logic [TMR_W-1:0]  ISO_LOAD   = dly_load(ISO_DLY);
    localparam logic [TMR_W-1:0]  PWRUP_LOAD = dly_load(PWRUP_DLY);
    localparam logic [TMR_W-1:0]  RST_LOAD   = dly_load(RST_CYCLES);

    pwr_state_t        state_q, state_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [WAKE_W-1:0] wake_cnt_q, wake_cnt_d;
    logic              pwr_down_q, pwr_down_d;
    logic              iso_enable_q, iso_enable_d;
    logic              pwron_reset_q, pwron_reset_d;

    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_load_val;
    logic              tmr_done;
    logic              tmr_done_next;

    logic              idle_qual;
    logic              wake_req;

    assign idle_qual = pwr_en & exec_idle & ~ififo_rdy;
    assign wake_req  = ififo_rdy | ~pwr_en;

    pwr_seq_timer u_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (tmr_load),
        .load_val  (tmr_load_val),
        .done      (tmr_done),
        .done_next (tmr_done_next)
    );

    always_comb begin
        state_d      = state_q;
        idle_cnt_d   = '0;
        wake_cnt_d   = wake_cnt_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;

        unique case (state_q)
            ST_ON: begin
                if (idle_qual) begin
                    if (idle_cnt_q == IDLE_LAST) begin
                        state_d      = ST_ISO;
                        tmr_load     = 1'b1;
                        tmr_load_val = ISO_LOAD;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end
            end
            ST_ISO: begin
                // Power was never removed, so an abort needs no reset sequence.
                if (wake_req) begin
                    state_d = ST_ON;
                end else if (tmr_done) begin
                    state_d = ST_OFF;
                end
            end
            ST_OFF: begin
                if (wake_req) begin
                    state_d      = ST_PWRUP;
                    tmr_load     = 1'b1;
                    tmr_load_val = PWRUP_LOAD;
                end
            end
            ST_PWRUP: begin
                if (tmr_done) begin
                    state_d      = ST_RSTREL;
                    tmr_load     = 1'b1;
                    tmr_load_val = RST_LOAD;
                end
            end
            ST_RSTREL: begin
                if (tmr_done) begin
                    state_d = ST_ON;
                    if (wake_cnt_q != {WAKE_W{1'b1}}) begin
                        wake_cnt_d = wake_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_ON;
            end
        endcase

        // Outputs are decoded from the next state so they change on the same edge as the state.
        pwr_down_d    = (state_d == ST_OFF);
        iso_enable_d  = (state_d != ST_ON);
        pwron_reset_d = (state_d == ST_PWRUP) || (state_d == ST_RSTREL);
    end

`ifdef PWR_SEQ_RETENTION_EN
    logic ret_save_q, ret_save_d;
    logic ret_restore_q, ret_restore_d;

    // Save strobes in the ISO cycle whose timer reads zero, i.e. the last one before OFF.
    assign ret_save_d    = (state_d == ST_ISO) && tmr_done_next;
    assign ret_restore_d = (state_q == ST_RSTREL) && (state_d == ST_ON);
    assign ret_save      = ret_save_q;
    assign ret_restore   = ret_restore_q;
`else
    logic unused_tmr_done_next;
    assign unused_tmr_done_next = tmr_done_next;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_ON;
            idle_cnt_q    <= '0;
            wake_cnt_q    <= '0;
            pwr_down_q    <= 1'b0;
            iso_enable_q  <= 1'b0;
            pwron_reset_q <= 1'b0;
`ifdef PWR_SEQ_RETENTION_EN
            ret_save_q    <= 1'b0;
            ret_restore_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            idle_cnt_q    <= idle_cnt_d;
            wake_cnt_q    <= wake_cnt_d;
            pwr_down_q    <= pwr_down_d;
            iso_enable_q  <= iso_enable_d;
            pwron_reset_q <= pwron_reset_d;
`ifdef PWR_SEQ_RETENTION_EN
            ret_save_q    <= ret_save_d;
            ret_restore_q <= ret_restore_d;
`endif
        end
    end

    assign pwr_down    = pwr_down_q;
    assign iso_enable  = iso_enable_q;
    assign pwron_reset = pwron_reset_q;
    assign pwr_state   = state_q;
    assign wake_cnt    = wake_cnt_q;

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// Directed-vector bench for pwr_seq_ctrl with IDLE_CYCLES=4, ISO_DLY=2, PWRUP_DLY=3, RST_CYCLES=2.
// Retention strobes are checked when PWR_SEQ_RETENTION_EN is defined.
module tb_pwr_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pwr_en = 1'b1;
    logic        ififo_rdy = 1'b0;
    logic        exec_idle = 1'b1;
    logic        pwr_down;
    logic        iso_enable;
    logic        pwron_reset;
    logic [2:0]  pwr_state;
    logic [15:0] wake_cnt;
`ifdef PWR_SEQ_RETENTION_EN
    logic        ret_save;
    logic        ret_restore;
`endif

    always #5 clk = ~clk;

    pwr_seq_ctrl #(
        .IDLE_CYCLES (4),
        .ISO_DLY     (2),
        .PWRUP_DLY   (3),
        .RST_CYCLES  (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pwr_en      (pwr_en),
        .ififo_rdy   (ififo_rdy),
        .exec_idle   (exec_idle),
        .pwr_down    (pwr_down),
        .iso_enable  (iso_enable),
        .pwron_reset (pwron_reset),
        .pwr_state   (pwr_state),
        .wake_cnt    (wake_cnt)
`ifdef PWR_SEQ_RETENTION_EN
        ,
        .ret_save    (ret_save),
        .ret_restore (ret_restore)
`endif
    );

    typedef struct {
        logic        rst;
        logic        pe;
        logic        ff;
        logic        ex;
        logic [2:0]  st;
        logic        pd;
        logic        iso;
        logic        por;
        logic [15:0] wk;
        logic        sv;
        logic        rs;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(input logic r, input logic pe, input logic ff, input logic ex,
                                input logic [2:0] st, input logic pd, input logic iso,
                                input logic por, input logic [15:0] wk, input logic sv,
                                input logic rs);
        vec_t v;
        v.rst = r;  v.pe = pe;   v.ff = ff;   v.ex = ex;
        v.st  = st; v.pd = pd;   v.iso = iso; v.por = por;
        v.wk  = wk; v.sv = sv;   v.rs = rs;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %0h, expected %0h", name, idx, got, exp);
        end
    endtask

    // Expected values are the outputs sampled after the edge that consumes the inputs.
    task automatic idle_to_on(input int n, input logic [15:0] wk);
        for (int i = 0; i < n; i++) vecs.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, wk, 0, 0));
    endtask

    task automatic idle_to_off(input logic [15:0] wk);
        idle_to_on(3, wk);
        vecs.push_back(mk(1, 1, 0, 1, 1, 0, 1, 0, wk, 0, 0));
        vecs.push_back(mk(1, 1, 0, 1, 1, 0, 1, 0, wk, 1, 0));
        vecs.push_back(mk(1, 1, 0, 1, 2, 1, 1, 0, wk, 0, 0));
    endtask

    initial begin
        int   woke;
        int   seen_on;
        int   glitch;
        int   saves;
        int   restores;
        int   saves_at_off;

        // reset
        vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        // idle entry: ISO after 4 qualifying cycles, OFF two cycles later
        idle_to_off(0);
        vecs.push_back(mk(1, 1, 0, 0, 2, 1, 1, 0, 0, 0, 0));
        // wake: 3 PWRUP, 2 RSTREL (wake and disable ignored), then ON
        vecs.push_back(mk(1, 1, 1, 1, 3, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 1, 3, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 3, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 1, 4, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 4, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1));
        // idle interrupted by exec_idle drop at cycle 2: ISO only after cycle 6
        idle_to_on(2, 1);
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        idle_to_on(3, 1);
        vecs.push_back(mk(1, 1, 0, 1, 1, 0, 1, 0, 1, 0, 0));
        // ISO abort by ififo_rdy in first ISO cycle
        vecs.push_back(mk(1, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0));
        // ififo_rdy in ON clears the idle count
        idle_to_on(3, 1);
        vecs.push_back(mk(1, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0));
        idle_to_on(3, 1);
        vecs.push_back(mk(1, 1, 0, 1, 1, 0, 1, 0, 1, 0, 0));
        // ISO abort by pwr_en=0
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
        // reset while OFF
        idle_to_off(1);
        vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        // wake from OFF by pwr_en=0
        idle_to_off(0);
        vecs.push_back(mk(1, 0, 0, 1, 3, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 1, 3, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 1, 3, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 1, 4, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 1, 4, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 1, 0, 1));

        foreach (vecs[i]) begin
            @(negedge clk);
            rst       = vecs[i].rst;
            pwr_en    = vecs[i].pe;
            ififo_rdy = vecs[i].ff;
            exec_idle = vecs[i].ex;
            @(posedge clk);
            #1;
            chk("pwr_state", i, 32'(pwr_state), 32'(vecs[i].st));
            chk("pwr_down", i, 32'(pwr_down), 32'(vecs[i].pd));
            chk("iso_enable", i, 32'(iso_enable), 32'(vecs[i].iso));
            chk("pwron_reset", i, 32'(pwron_reset), 32'(vecs[i].por));
            chk("wake_cnt", i, 32'(wake_cnt), 32'(vecs[i].wk));
`ifdef PWR_SEQ_RETENTION_EN
            chk("ret_save", i, 32'(ret_save), 32'(vecs[i].sv));
            chk("ret_restore", i, 32'(ret_restore), 32'(vecs[i].rs));
`endif
        end

        // Saturation: preload the wake counter to all-ones, then run a full sleep/wake cycle.
        @(negedge clk);
        rst       = 1'b1;
        pwr_en    = 1'b1;
        ififo_rdy = 1'b0;
        exec_idle = 1'b1;
        force dut.wake_cnt_q = 16'hFFFF;
        #1;
        release dut.wake_cnt_q;
        #1;
        chk("wake_preload", 0, 32'(wake_cnt), 32'h0000FFFF);

        woke = 0; seen_on = 0; glitch = 0;
        saves = 0; restores = 0; saves_at_off = -1;
        for (int c = 0; c < 40 && seen_on == 0; c++) begin
            @(negedge clk);
            ififo_rdy = (pwr_state == 3'd2 && woke == 0);
            if (ififo_rdy) woke = 1;
            @(posedge clk);
            #1;
            if (pwr_down && !iso_enable) glitch++;
`ifdef PWR_SEQ_RETENTION_EN
            if (ret_save) saves++;
            if (ret_restore) restores++;
`endif
            if (pwr_state == 3'd2 && saves_at_off < 0) saves_at_off = saves;
            if (woke != 0 && pwr_state == 3'd0) seen_on = 1;
        end
        chk("wake_seq_done", 0, 32'(seen_on), 32'd1);
        chk("wake_saturated", 0, 32'(wake_cnt), 32'h0000FFFF);
        chk("pd_without_iso", 0, 32'(glitch), 32'd0);
        chk("por_after_wake", 0, 32'(pwron_reset), 32'd0);
`ifdef PWR_SEQ_RETENTION_EN
        chk("ret_save_before_off", 0, 32'(saves_at_off), 32'd1);
        chk("ret_save_count", 0, 32'(saves), 32'd1);
        chk("ret_restore_count", 0, 32'(restores), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
